// File: rtl/vscale_mul_div_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, shift-add multiply, restoring divide.
// Optional MUL_DIV_EARLY_OUT_EN: zero-operand multiplies and zero-divisor divides bypass the iteration.
module vscale_mul_div_iter #(
  parameter int XPR_LEN = 32,
  parameter int CNT_W   = $clog2(XPR_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [XPR_LEN-1:0] req_in_1,
  input  logic [XPR_LEN-1:0] req_in_2,
  input  logic               req_kill,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XPR_LEN-1:0] resp_out
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XPR_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIXUP, S_DONE} state_t;

  state_t                   state_reg, state_next;
  logic [2:0]               op_reg;
  logic [XPR_LEN-1:0]       opnd_reg;
  logic                     neg_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [2*XPR_LEN-1:0]     acc_reg;
  logic [XPR_LEN-1:0]       resp_out_reg;

  logic                     accept;
  logic                     sign_1, sign_2;
  logic [XPR_LEN-1:0]       abs_1, abs_2;
  logic                     neg_in;
  logic                     zero_2;
  logic [2*XPR_LEN-1:0]     acc_init;
  logic [XPR_LEN-1:0]       opnd_init;
  logic                     early_out;

  // Operand preparation on the accepting edge
  always_comb begin
    sign_1 = 1'b0;
    sign_2 = 1'b0;
    case (req_op)
      OP_MULH, OP_DIV, OP_REM: begin
        sign_1 = req_in_1[XPR_LEN-1];
        sign_2 = req_in_2[XPR_LEN-1];
      end
      OP_MULHSU: sign_1 = req_in_1[XPR_LEN-1];
      default: ;
    endcase
    abs_1  = sign_1 ? -req_in_1 : req_in_1;
    abs_2  = sign_2 ? -req_in_2 : req_in_2;
    zero_2 = (req_in_2 == {XPR_LEN{1'b0}});

    // A zero divisor leaves the quotient all ones; suppressing negation keeps it that way.
    if (req_op[2] == 1'b0)
      neg_in = sign_1 ^ sign_2;
    else if (req_op[1] == 1'b0)
      neg_in = (sign_1 ^ sign_2) && !zero_2;
    else
      neg_in = sign_1;

    if (req_op[2]) begin
      opnd_init = abs_2;
      acc_init  = {{XPR_LEN{1'b0}}, abs_1};
    end else begin
      opnd_init = abs_1;
      acc_init  = {{XPR_LEN{1'b0}}, abs_2};
    end

`ifdef MUL_DIV_EARLY_OUT_EN
    if (req_op[2])
      early_out = zero_2;
    else
      early_out = (req_in_1 == {XPR_LEN{1'b0}}) || zero_2;
    // Preload the state the full iteration would have reached
    if (early_out)
      acc_init = req_op[2] ? {abs_1, {XPR_LEN{1'b1}}} : {2*XPR_LEN{1'b0}};
`else
    early_out = 1'b0;
`endif
  end

  // One iteration step for each algorithm
  logic [XPR_LEN:0]         mul_sum;
  logic [2*XPR_LEN-1:0]     mul_step;
  logic [XPR_LEN:0]         div_ext;
  logic [XPR_LEN-1:0]       div_diff;
  logic                     div_ge;
  logic [2*XPR_LEN-1:0]     div_step;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*XPR_LEN-1:XPR_LEN]}
             + (acc_reg[0] ? {1'b0, opnd_reg} : {(XPR_LEN+1){1'b0}});
    mul_step = {mul_sum, acc_reg[XPR_LEN-1:1]};

    // Partial remainder after the shift can need one extra bit
    div_ext  = acc_reg[2*XPR_LEN-1:XPR_LEN-1];
    div_ge   = (div_ext >= {1'b0, opnd_reg});
    div_diff = div_ext[XPR_LEN-1:0] - opnd_reg;
    div_step = div_ge ? {div_diff, acc_reg[XPR_LEN-2:0], 1'b1}
                      : {div_ext[XPR_LEN-1:0], acc_reg[XPR_LEN-2:0], 1'b0};
  end

  // Sign fix-up and field select
  logic [2*XPR_LEN-1:0]     prod_fix;
  logic [XPR_LEN-1:0]       quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_reg ? -acc_reg : acc_reg;
    quo_fix  = neg_reg ? -acc_reg[XPR_LEN-1:0] : acc_reg[XPR_LEN-1:0];
    rem_fix  = neg_reg ? -acc_reg[2*XPR_LEN-1:XPR_LEN] : acc_reg[2*XPR_LEN-1:XPR_LEN];
    case (op_reg)
      OP_MUL:                       fix_result = prod_fix[XPR_LEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XPR_LEN-1:XPR_LEN];
      OP_DIV, OP_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = (state_reg == S_IDLE) && !req_kill;
    resp_valid = (state_reg == S_DONE);
    accept     = req_valid && req_ready;
    case (state_reg)
      S_IDLE:  if (accept) state_next = early_out ? S_FIXUP : S_BUSY;
      S_BUSY:  if (cnt_reg == {CNT_W{1'b0}}) state_next = S_FIXUP;
      S_FIXUP: state_next = S_DONE;
      S_DONE:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (req_kill)
      state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg       <= 3'd0;
      opnd_reg     <= {XPR_LEN{1'b0}};
      neg_reg      <= 1'b0;
      cnt_reg      <= {CNT_W{1'b0}};
      acc_reg      <= {2*XPR_LEN{1'b0}};
      resp_out_reg <= {XPR_LEN{1'b0}};
    end else begin
      if (accept) begin
        op_reg   <= req_op;
        opnd_reg <= opnd_init;
        neg_reg  <= neg_in;
        cnt_reg  <= CNT_LAST;
        acc_reg  <= acc_init;
      end else if (state_reg == S_BUSY && !req_kill) begin
        acc_reg <= op_reg[2] ? div_step : mul_step;
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (state_reg == S_FIXUP && !req_kill)
        resp_out_reg <= fix_result;
    end
  end

  assign resp_out = resp_out_reg;

endmodule
